// File: rtl/netdma_read_dispatcher_if.sv
// Bus bundle for the read dispatcher: descriptor FIFO head/pop, Avalon-MM read
// master, and the framed word stream into the TX data buffer.
// Handshakes: the FIFO entry is consumed in the cycle desc_buf_rdreq_o is high.
// An Avalon read transfers when rd_read_o & !rd_waitrequest_i. Until then the
// master holds read, address and burstcount stable. Returned words have no
// backpressure: rd_readdatavalid_i and data_valid_o each qualify one word.
interface netdma_read_dispatcher_if #(
    parameter int BC_W = 4
);
    logic [63:0]     descriptor_i;
    logic            desc_buf_empty_i;
    logic            desc_buf_rdreq_o;
    logic [31:0]     rd_address_o;
    logic            rd_read_o;
    logic [BC_W-1:0] rd_burstcount_o;
    logic            rd_waitrequest_i;
    logic [31:0]     rd_readdata_i;
    logic            rd_readdatavalid_i;
    logic [31:0]     data_o;
    logic            data_valid_o;
    logic            data_sop_o;
    logic            data_eop_o;

    modport master (
        input  descriptor_i, desc_buf_empty_i, rd_waitrequest_i,
               rd_readdata_i, rd_readdatavalid_i,
        output desc_buf_rdreq_o, rd_address_o, rd_read_o, rd_burstcount_o,
               data_o, data_valid_o, data_sop_o, data_eop_o
    );

    modport slave (
        output descriptor_i, desc_buf_empty_i, rd_waitrequest_i,
               rd_readdata_i, rd_readdatavalid_i,
        input  desc_buf_rdreq_o, rd_address_o, rd_read_o, rd_burstcount_o,
               data_o, data_valid_o, data_sop_o, data_eop_o
    );
endinterface

// File: rtl/netdma_read_dispatcher.sv
// Read dispatcher: pops one descriptor at a time from the show-ahead FIFO,
// splits it into Avalon read bursts of at most MAX_BURST words while keeping
// no more than MAX_OUTSTANDING words in flight, and forwards the returned
// words to the TX buffer framed with sop/eop, pulsing desc_done_o at the end.
module netdma_read_dispatcher #(
    parameter  int MAX_BURST       = 8,
    parameter  int MAX_OUTSTANDING = 32,
    localparam int BC_W            = $clog2(MAX_BURST) + 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           enable_i,
    netdma_read_dispatcher_if.master       bus,
    output logic                           desc_done_o,
    output logic                           busy_o,
    output logic [1:0]                     o_dbg_state
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW    = OUT_W + BC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_active;      // low through reset so no pop is issued while held
    logic [31:0]      r_addr;
    logic [15:0]      r_len;
    logic [15:0]      r_remaining;
    logic [15:0]      r_returned;
    logic [BC_W-1:0]  r_burst;
    logic             r_rd_read;
    logic [OUT_W-1:0] r_outstanding;
    logic [31:0]      r_data;
    logic             r_data_valid;
    logic             r_sop;
    logic             r_eop;
    logic             r_desc_done;

    logic             w_go;
    logic [15:0]      w_len;
    logic             w_pop;
    logic             w_accept;
    logic             w_ret;
    logic [15:0]      w_rem_after;
    logic [OUT_W-1:0] w_out_after;
    logic [BC_W-1:0]  w_next_burst;
    logic [BC_W-1:0]  w_len_burst;
    logic [31:0]      w_addr_step;
    logic             w_unused;

    // Words in the next burst: the remaining count capped at MAX_BURST.
    function automatic logic [BC_W-1:0] f_burst(input logic [15:0] rem);
        if (rem >= 16'(MAX_BURST)) return BC_W'(MAX_BURST);
        return BC_W'(rem);
    endfunction

    // A burst may be requested only if it keeps in-flight words within credit.
    function automatic logic f_fits(input logic [OUT_W-1:0] outs, input logic [BC_W-1:0] b);
        return (CW'(outs) + CW'(b)) <= CW'(MAX_OUTSTANDING);
    endfunction

    // Next-state helpers shared by the issue and return paths.
    always_comb begin
        w_go         = bus.descriptor_i[63];
        w_len        = bus.descriptor_i[47:32];
        w_pop        = r_active && (r_state == S_IDLE) && enable_i &&
                       !bus.desc_buf_empty_i && !r_desc_done;
        w_accept     = r_rd_read && !bus.rd_waitrequest_i;
        w_ret        = bus.rd_readdatavalid_i && (r_outstanding != '0);
        w_rem_after  = w_accept ? (r_remaining - 16'(r_burst)) : r_remaining;
        w_out_after  = r_outstanding + (w_accept ? OUT_W'(r_burst) : '0)
                                     - (w_ret ? OUT_W'(1) : '0);
        w_next_burst = f_burst(w_rem_after);
        w_len_burst  = f_burst(w_len);
        w_addr_step  = 32'({r_burst, 2'b00});
        w_unused     = ^{bus.descriptor_i[62:48], bus.descriptor_i[1:0]};
    end

    // Dispatcher FSM, credit counter and registered return path.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_active      <= 1'b0;
            r_addr        <= '0;
            r_len         <= '0;
            r_remaining   <= '0;
            r_returned    <= '0;
            r_burst       <= '0;
            r_rd_read     <= 1'b0;
            r_outstanding <= '0;
            r_data        <= '0;
            r_data_valid  <= 1'b0;
            r_sop         <= 1'b0;
            r_eop         <= 1'b0;
            r_desc_done   <= 1'b0;
        end else begin
            r_active      <= 1'b1;
            r_desc_done   <= 1'b0;
            r_outstanding <= w_out_after;
            r_data_valid  <= w_ret;
            r_sop         <= 1'b0;
            r_eop         <= 1'b0;
            // Words arriving with nothing outstanding are stale and dropped.
            if (w_ret) begin
                r_data     <= bus.rd_readdata_i;
                r_sop      <= (r_returned == 16'd0);
                r_eop      <= (r_returned == (r_len - 16'd1));
                r_returned <= r_returned + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    // go=0 entries are popped and silently discarded.
                    if (w_pop && w_go) begin
                        if (w_len == 16'd0) begin
                            r_desc_done <= 1'b1;
                        end else begin
                            r_addr      <= {bus.descriptor_i[31:2], 2'b00};
                            r_len       <= w_len;
                            r_remaining <= w_len;
                            r_returned  <= '0;
                            r_burst     <= w_len_burst;
                            r_rd_read   <= f_fits(w_out_after, w_len_burst);
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_accept) begin
                        r_addr      <= r_addr + w_addr_step;
                        r_remaining <= w_rem_after;
                        if (w_rem_after == 16'd0) begin
                            r_rd_read <= 1'b0;
                            r_burst   <= '0;
                            r_state   <= S_DRAIN;
                        end else begin
                            r_burst   <= w_next_burst;
                            r_rd_read <= f_fits(w_out_after, w_next_burst);
                        end
                    end else if (!r_rd_read) begin
                        // Credit only grows while waiting, so a raised read stays raised.
                        r_rd_read <= f_fits(w_out_after, r_burst);
                    end
                end
                S_DRAIN: begin
                    if (r_returned == r_len) begin
                        r_desc_done <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.desc_buf_rdreq_o = w_pop;
    assign bus.rd_address_o     = r_addr;
    assign bus.rd_read_o        = r_rd_read;
    assign bus.rd_burstcount_o  = r_burst;
    assign bus.data_o           = r_data;
    assign bus.data_valid_o     = r_data_valid;
    assign bus.data_sop_o       = r_sop;
    assign bus.data_eop_o       = r_eop;
    assign desc_done_o          = r_desc_done;
    assign busy_o               = (r_state != S_IDLE) || (r_outstanding != '0);
    assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_netdma_read_dispatcher.sv
// Bench for netdma_read_dispatcher: a descriptor FIFO model, an Avalon memory
// model with random stalls and latency, and a descriptor-level scoreboard.
module tb_netdma_read_dispatcher;
  localparam int MAX_BURST = 8;
  localparam int MAX_OUT   = 32;
  localparam int BC_W      = 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i;
  logic enable_i;
  logic desc_done_o;
  logic busy_o;
  logic [1:0] dbg_state;

  always #5 clk_i = ~clk_i;

  netdma_read_dispatcher_if #(.BC_W(BC_W)) bus ();

  netdma_read_dispatcher #(.MAX_BURST(MAX_BURST), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .bus         (bus),
    .desc_done_o (desc_done_o),
    .busy_o      (busy_o),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [63:0] fifo_q[$];
  logic [33:0] exp_q[$];        // {sop, eop, data}
  logic [35:0] exp_burst_q[$];  // {burstcount, address}
  logic [31:0] mem_addr_q[$];
  int          mem_rdy_q[$];
  bit          mem_stale_q[$];

  int lat_min = 1, lat_max = 1;
  bit rand_wait = 0, rand_rv = 0, en_knob = 1;
  int force_wait_left = 0;

  int bursts_seen, words_seen, dones_seen, dones_exp, pops_seen, max_out, stall_seen;
  logic [31:0] log_addr[$];
  int          log_bc[$];

  bit          last_rdreq, drove_valid, eop_last, prev_stall, zero_done, exp_done, w;
  logic [31:0] prev_addr;
  logic [BC_W-1:0] prev_bc;
  logic [33:0] e;
  logic [35:0] b;
  int          live;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int live_words();
    int n = 0;
    foreach (mem_stale_q[i]) if (!mem_stale_q[i]) n++;
    return n;
  endfunction

  // Reference model: a popped descriptor expands into its burst list and word list.
  task automatic model_pop(input logic [63:0] d);
    logic [31:0] a;
    int len, rem, bl;
    pops_seen++;
    if (d[63]) begin
      dones_exp++;
      len = int'(d[47:32]);
      if (len == 0) begin
        zero_done = 1;
      end else begin
        a = {d[31:2], 2'b00};
        for (int i = 0; i < len; i++)
          exp_q.push_back({(i == 0), (i == len - 1), mem_word(a + 32'(4 * i))});
        rem = len;
        while (rem > 0) begin
          bl = (rem > MAX_BURST) ? MAX_BURST : rem;
          exp_burst_q.push_back({4'(bl), a});
          a = a + 32'(4 * bl);
          rem -= bl;
        end
      end
    end
  endtask

  task automatic clear_stats();
    bursts_seen = 0; words_seen = 0; dones_seen = 0; dones_exp = 0;
    pops_seen = 0; max_out = 0; stall_seen = 0;
    log_addr.delete(); log_bc.delete();
  endtask

  // ---------------- compare process + bus models (every falling edge) ----------------
  always @(negedge clk_i) begin
    cyc++;
    if (rst_i) begin
      check({bus.desc_buf_rdreq_o, bus.rd_read_o, bus.rd_address_o, bus.rd_burstcount_o,
             bus.data_o, bus.data_valid_o, bus.data_sop_o, bus.data_eop_o, desc_done_o, busy_o} == '0,
            "reset_outputs", {bus.rd_read_o, bus.data_valid_o, desc_done_o, busy_o}, 0);
      exp_q.delete();
      exp_burst_q.delete();
      foreach (mem_stale_q[i]) mem_stale_q[i] = 1;
      bus.rd_readdatavalid_i = 0;
      bus.rd_waitrequest_i   = 0;
      drove_valid = 0; last_rdreq = 0; prev_stall = 0; eop_last = 0;
    end else begin
      zero_done = 0;
      if (last_rdreq) begin
        if (fifo_q.size() == 0) check(0, "pop_empty", 1, 0);
        else model_pop(fifo_q.pop_front());
      end
      if (exp_q.size() != 0 || exp_burst_q.size() != 0) check(busy_o == 1'b1, "busy", busy_o, 1);

      exp_done = zero_done || eop_last;
      check(desc_done_o == exp_done, "desc_done", desc_done_o, exp_done);
      if (desc_done_o) dones_seen++;

      check(bus.data_valid_o == drove_valid, "data_valid", bus.data_valid_o, drove_valid);
      eop_last = 0;
      if (drove_valid) begin
        if (exp_q.size() == 0) begin
          check(0, "data_unexpected", bus.data_o, 0);
        end else begin
          e = exp_q.pop_front();
          if (bus.data_valid_o)
            check({bus.data_sop_o, bus.data_eop_o, bus.data_o} == e, "data_word",
                  {bus.data_sop_o, bus.data_eop_o, bus.data_o}, e);
          eop_last = e[32];
          words_seen++;
        end
      end

      if (prev_stall)
        check({bus.rd_read_o, bus.rd_address_o, bus.rd_burstcount_o} == {1'b1, prev_addr, prev_bc},
              "stall_hold", {bus.rd_read_o, bus.rd_address_o, bus.rd_burstcount_o},
              {1'b1, prev_addr, prev_bc});

      // memory return side
      if (mem_addr_q.size() != 0 && mem_rdy_q[0] <= cyc && (!rand_rv || $urandom_range(0, 3) != 0)) begin
        bus.rd_readdatavalid_i = 1;
        bus.rd_readdata_i      = mem_word(mem_addr_q[0]);
        drove_valid            = !mem_stale_q[0];
        void'(mem_addr_q.pop_front());
        void'(mem_rdy_q.pop_front());
        void'(mem_stale_q.pop_front());
      end else begin
        bus.rd_readdatavalid_i = 0;
        bus.rd_readdata_i      = $urandom;
        drove_valid            = 0;
      end

      // memory request side
      if (bus.rd_read_o && force_wait_left > 0 && bursts_seen == 1) begin
        w = 1; force_wait_left--; stall_seen++;
      end else begin
        w = rand_wait && ($urandom_range(0, 2) == 0);
      end
      bus.rd_waitrequest_i = w;
      if (bus.rd_read_o && !w) begin
        if (exp_burst_q.size() == 0) begin
          check(0, "extra_burst", {bus.rd_burstcount_o, bus.rd_address_o}, 0);
        end else begin
          b = exp_burst_q.pop_front();
          check({bus.rd_burstcount_o, bus.rd_address_o} == b, "burst",
                {bus.rd_burstcount_o, bus.rd_address_o}, b);
        end
        for (int i = 0; i < int'(bus.rd_burstcount_o); i++) begin
          mem_addr_q.push_back(bus.rd_address_o + 32'(4 * i));
          mem_rdy_q.push_back(cyc + $urandom_range(lat_min, lat_max));
          mem_stale_q.push_back(0);
        end
        bursts_seen++;
        log_addr.push_back(bus.rd_address_o);
        log_bc.push_back(int'(bus.rd_burstcount_o));
        live = live_words();
        if (live > max_out) max_out = live;
        check(live <= MAX_OUT, "outstanding", live, MAX_OUT);
      end
      prev_stall = bus.rd_read_o && w;
      prev_addr  = bus.rd_address_o;
      prev_bc    = bus.rd_burstcount_o;
    end

    // descriptor FIFO head
    enable_i             = en_knob;
    bus.desc_buf_empty_i = (fifo_q.size() == 0);
    bus.descriptor_i     = (fifo_q.size() == 0) ? {$urandom, $urandom} : fifo_q[0];
    #1;
    last_rdreq = rst_i ? 1'b0 : bus.desc_buf_rdreq_o;
  end

  // ---------------- driver tasks ----------------
  task automatic push_desc(input bit go, input int len, input logic [31:0] addr);
    fifo_q.push_back({go, 15'($urandom), 16'(len), addr});
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk_i);
      if (fifo_q.size() == 0 && exp_q.size() == 0 && exp_burst_q.size() == 0 &&
          mem_addr_q.size() == 0 && !last_rdreq) break;
    end
    if (i >= budget) check(0, "timeout", fifo_q.size() + exp_q.size(), 0);
    repeat (4) @(posedge clk_i);
    #2;
    check(busy_o == 1'b0, "idle_busy", busy_o, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1; enable_i = 0;
    bus.descriptor_i = '0; bus.desc_buf_empty_i = 1; bus.rd_waitrequest_i = 0;
    bus.rd_readdata_i = '0; bus.rd_readdatavalid_i = 0;
    clear_stats();
    repeat (3) @(posedge clk_i);
    #2 rst_i = 0;
    repeat (2) @(posedge clk_i);

    // 1: single short burst
    clear_stats(); lat_min = 1; lat_max = 3;
    #2 push_desc(1, 3, 32'h0000_1000);
    wait_idle(200);
    check(log_addr.size() == 1 && log_addr[0] == 32'h1000 && log_bc[0] == 3, "t1_burst",
          log_addr.size() ? log_addr[0] : 0, 32'h1000);
    check(words_seen == 3, "t1_words", words_seen, 3);
    check(dones_seen == 1, "t1_done", dones_seen, 1);

    // 2: split into 8/8/4
    clear_stats();
    #2 push_desc(1, 20, 32'h0000_1000);
    wait_idle(300);
    check(log_addr.size() == 3, "t2_nbursts", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      check({log_addr[0], log_addr[1], log_addr[2]} == {32'h1000, 32'h1020, 32'h1040},
            "t2_addrs", log_addr[2], 32'h1040);
      check(log_bc[0] == 8 && log_bc[1] == 8 && log_bc[2] == 4, "t2_bcs", log_bc[2], 4);
    end
    check(words_seen == 20 && dones_seen == 1, "t2_words_done", words_seen, 20);

    // 3: five stall cycles on the second burst
    clear_stats(); force_wait_left = 5;
    #2 push_desc(1, 20, 32'h0000_2000);
    wait_idle(300);
    check(stall_seen == 5, "t3_stalls", stall_seen, 5);
    check(log_addr.size() == 3, "t3_nbursts", log_addr.size(), 3);
    if (log_addr.size() > 1) check(log_addr[1] == 32'h2020, "t3_addr2", log_addr[1], 32'h2020);

    // 4: slow memory, credit limit
    clear_stats(); lat_min = 40; lat_max = 40;
    #2 push_desc(1, 64, 32'h0000_3000);
    wait_idle(600);
    check(max_out == 32, "t4_max_outstanding", max_out, 32);
    check(log_addr.size() == 8 && words_seen == 64, "t4_bursts_words", log_addr.size(), 8);
    check(dones_seen == 1, "t4_done", dones_seen, 1);

    // 5: go=0 and zero-length descriptors
    clear_stats(); lat_min = 1; lat_max = 3;
    #2 push_desc(0, 5, 32'h0000_5000);
    push_desc(1, 0, 32'h0000_5000);
    wait_idle(100);
    check(pops_seen == 2, "t5_pops", pops_seen, 2);
    check(dones_seen == 1, "t5_done", dones_seen, 1);
    check(bursts_seen == 0, "t5_no_read", bursts_seen, 0);

    // 6: randomized descriptors, stalls, latency, enable toggling
    clear_stats(); rand_wait = 1; rand_rv = 1; lat_min = 1; lat_max = 12;
    for (int i = 0; i < 25; i++) begin
      #2;
      en_knob = ($urandom_range(0, 3) != 0);
      if (i % 6 == 0) push_desc(1, $urandom_range(1, 30), 32'hFFFF_FFC0 + 32'($urandom_range(0, 63)));
      else push_desc($urandom_range(0, 7) != 0, $urandom_range(0, 40), $urandom);
      repeat ($urandom_range(0, 15)) @(posedge clk_i);
    end
    #2 en_knob = 1;
    wait_idle(20000);
    check(dones_seen == dones_exp, "t6_dones", dones_seen, dones_exp);
    check(pops_seen == 25, "t6_pops", pops_seen, 25);

    // 7: reset with four words in flight; late words must be dropped
    clear_stats(); rand_wait = 0; rand_rv = 0; lat_min = 20; lat_max = 20;
    #2 push_desc(1, 4, 32'h0000_4000);
    for (int i = 0; i < 60 && bursts_seen == 0; i++) @(posedge clk_i);
    check(bursts_seen == 1, "t7_issued", bursts_seen, 1);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1;
    #1 check({busy_o, bus.rd_read_o, bus.data_valid_o, desc_done_o} == 4'b0, "t7_async_reset",
             {busy_o, bus.rd_read_o, bus.data_valid_o, desc_done_o}, 0);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 0;
    wait_idle(200);
    check(words_seen == 0 && dones_seen == 0, "t7_stale_dropped", words_seen, 0);

    // after reset the block still works
    clear_stats(); lat_min = 1; lat_max = 4;
    #2 push_desc(1, 5, 32'h0000_6002);
    wait_idle(200);
    check(log_addr.size() == 1 && log_addr[0] == 32'h6000, "t7_recover_addr",
          log_addr.size() ? log_addr[0] : 0, 32'h6000);
    check(words_seen == 5 && dones_seen == 1, "t7_recover_words", words_seen, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
